// File: rtl/mips_ctl_pkg.sv
// mips_ctl_pkg: shared states, ALU codes, opcode/func values and mux encodings for the multi-cycle control unit
package mips_ctl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b1010;
    localparam logic [3:0] ALU_ADDU = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1110;
    localparam logic [3:0] ALU_SUBU = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // ALU operation for the immediate-form arithmetic/logic opcodes
    function automatic logic [3:0] imm_alu(input logic [5:0] op);
        case (op)
            OP_ADDI:  return ALU_ADD;
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            default:  return ALU_ADDU;
        endcase
    endfunction

endpackage

// File: rtl/alu_func_decode.sv
// alu_func_decode: maps an R-type Func field to its ALU operation and flags unsupported codes
module alu_func_decode
    import mips_ctl_pkg::*;
(
    input  logic [5:0] func,
    output logic [3:0] alu_cntl,
    output logic       valid
);

    // table lookup; unknown Func falls back to addu with valid cleared
    always_comb begin
        alu_cntl = ALU_ADDU;
        valid    = 1'b1;
        case (func)
            F_ADD:   alu_cntl = ALU_ADD;
            F_ADDU:  alu_cntl = ALU_ADDU;
            F_SUB:   alu_cntl = ALU_SUB;
            F_SUBU:  alu_cntl = ALU_SUBU;
            F_AND:   alu_cntl = ALU_AND;
            F_OR:    alu_cntl = ALU_OR;
            F_XOR:   alu_cntl = ALU_XOR;
            F_NOR:   alu_cntl = ALU_NOR;
            F_SLT:   alu_cntl = ALU_SLT;
            F_SLTU:  alu_cntl = ALU_SLTU;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: MIPS multi-cycle control FSM with bounded memory wait, sticky error flags and retire counter
module multicycle_control
    import mips_ctl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       Branch,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUCntl,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t     state, state_nx, dec_nx;
    logic [5:0] op_q, func_q;
    logic [7:0] wcnt;
    logic [3:0] fcntl;
    logic       fvalid, mem_st, timeout, irw, pcw;
    logic       unused_zero;

    // the branch condition is resolved in the datapath from PCWriteCond/Branch
    assign unused_zero = Zero;

    assign mem_st  = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign timeout = mem_st && !mem_ready && wcnt == 8'(MEM_TIMEOUT - 1);

    // Func is live in DECODE (legality) and held afterwards for EXEC_R
    alu_func_decode u_fd (
        .func     (state == S_DECODE ? Func : func_q),
        .alu_cntl (fcntl),
        .valid    (fvalid)
    );

    // opcode dispatch out of DECODE; anything unsupported halts
    always_comb begin
        dec_nx = S_HALT;
        case (Op)
            OP_RTYPE:                          dec_nx = fvalid ? S_EXEC_R : S_HALT;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_ORI:         dec_nx = S_EXEC_I;
            OP_LW, OP_SW:                      dec_nx = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                    dec_nx = S_BRANCH;
            OP_J:                              dec_nx = S_JUMP;
            default:                           dec_nx = S_HALT;
        endcase
    end

    // next state and per-state strobes
    always_comb begin
        state_nx    = state;
        pcw         = 1'b0;
        irw         = 1'b0;
        PCWriteCond = 1'b0;
        Branch      = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUCntl     = ALU_AND;
        PCSource    = PCS_ALU;
        case (state)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ALUCntl  = ALU_ADDU;
                irw      = mem_ready;
                pcw      = mem_ready;
                state_nx = mem_ready ? S_DECODE : timeout ? S_HALT : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB  = SRCB_IMM_SH;
                ALUCntl  = ALU_ADDU;
                state_nx = dec_nx;
            end
            S_EXEC_R: begin
                ALUSrcA  = 1'b1;
                ALUCntl  = fcntl;
                state_nx = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                ALUCntl  = imm_alu(op_q);
                state_nx = S_WB_ALU;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = op_q == OP_RTYPE;
                state_nx = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                ALUCntl  = ALU_ADDU;
                state_nx = op_q == OP_LW ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                state_nx = mem_ready ? S_MEM_WB : timeout ? S_HALT : S_MEM_RD;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                state_nx = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_nx = mem_ready ? S_FETCH : timeout ? S_HALT : S_MEM_WR;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUCntl     = ALU_SUBU;
                PCWriteCond = 1'b1;
                PCSource    = PCS_ALUOUT;
                Branch      = op_q == OP_BEQ ? 2'b01 : 2'b10;
                state_nx    = S_FETCH;
            end
            S_JUMP: begin
                pcw      = 1'b1;
                PCSource = PCS_JUMP;
                state_nx = S_FETCH;
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_HALT;
        endcase
    end

    // instruction-register and PC loads must never fire while reset is held
    assign IRWrite = irw & rst_n;
    assign PCWrite = pcw & rst_n;

    // state, latched instruction fields, wait counter, sticky flags and retire count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            op_q    <= '0;
            func_q  <= '0;
            wcnt    <= '0;
            illegal <= 1'b0;
            fault   <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= state_nx != state ? 8'd0 : (mem_st && !mem_ready) ? wcnt + 8'd1 : wcnt;
            if (state == S_DECODE) begin
                op_q   <= Op;
                func_q <= Func;
            end
            if (state == S_DECODE && dec_nx == S_HALT)
                illegal <= 1'b1;
            if (timeout)
                fault <= 1'b1;
            if (state != S_FETCH && state_nx == S_FETCH)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench driving random instruction streams against a phase-level reference model
module tb_multicycle_control;

    localparam int T = 4;

    typedef struct packed {
        logic       pcw, pcwc;
        logic [1:0] br;
        logic       iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb;
        logic [3:0] alu;
        logic [1:0] pcs;
        logic       ill, flt;
        logic [3:0] ret;
    } ctl_t;

    localparam int PF = 0, PD = 1, PXR = 2, PXI = 3, PWB = 4, PMA = 5,
                   PMR = 6, PMWB = 7, PMW = 8, PBR = 9, PJ = 10, PH = 11;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [5:0] Op = '0, Func = '0;
    logic       Zero = 1'b0, mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, illegal, fault;
    logic [1:0] Branch, ALUSrcB, PCSource;
    logic [3:0] ALUCntl, retired;

    int   checks = 0, errors = 0;
    ctl_t q[$];
    int   pq[$];
    logic [3:0] m_ret;
    logic       m_ill, m_flt;

    logic [5:0] ops[12]  = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    logic [5:0] fns[10]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Func(Func), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUCntl(ALUCntl), .PCSource(PCSource), .illegal(illegal), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic string pname(input int ph);
        string n[12] = '{"fetch", "decode", "exec_r", "exec_i", "wb_alu", "mem_addr",
                         "mem_rd", "mem_wb", "mem_wr", "branch", "jump", "halt"};
        return n[ph];
    endfunction

    function automatic logic [3:0] alu_r(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'b1010; 6'h21: return 4'b0010; 6'h22: return 4'b1110; 6'h23: return 4'b0110;
            6'h24: return 4'b0000; 6'h25: return 4'b0001; 6'h26: return 4'b0011; 6'h27: return 4'b1100;
            6'h2A: return 4'b1101; default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] alu_i(input logic [5:0] op);
        case (op)
            6'h08: return 4'b1010; 6'h09: return 4'b0010; 6'h0C: return 4'b0000;
            6'h0D: return 4'b0001; 6'h0A: return 4'b1101; default: return 4'b1111;
        endcase
    endfunction

    function automatic ctl_t ev(input int ph, input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        ctl_t e;
        e = '0;
        e.ill = m_ill; e.flt = m_flt; e.ret = m_ret;
        case (ph)
            PF:   begin e.mrd = 1; e.srcb = 2'b01; e.alu = 4'b0010; e.irw = rdy & rst_n; e.pcw = rdy & rst_n; end
            PD:   begin e.srcb = 2'b11; e.alu = 4'b0010; end
            PXR:  begin e.srca = 1; e.alu = alu_r(fn); end
            PXI:  begin e.srca = 1; e.srcb = 2'b10; e.alu = alu_i(op); end
            PWB:  begin e.rw = 1; e.rdst = (op == 6'h00); end
            PMA:  begin e.srca = 1; e.srcb = 2'b10; e.alu = 4'b0010; end
            PMR:  begin e.mrd = 1; e.iord = 1; end
            PMWB: begin e.rw = 1; e.m2r = 1; end
            PMW:  begin e.mwr = 1; e.iord = 1; end
            PBR:  begin e.srca = 1; e.alu = 4'b0110; e.pcwc = 1; e.pcs = 2'b01; e.br = (op == 6'h04) ? 2'b01 : 2'b10; end
            PJ:   begin e.pcw = 1; e.pcs = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    // one clock cycle of stimulus; Op/Func carry noise outside DECODE
    task automatic cyc(input int ph, input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        mem_ready = rdy;
        Zero      = 1'($urandom);
        Op        = (ph == PD) ? op : 6'($urandom);
        Func      = (ph == PD) ? fn : 6'($urandom);
        q.push_back(ev(ph, op, fn, rdy));
        pq.push_back(ph);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_ret = '0; m_ill = 0; m_flt = 0;
        rst_n = 1'b0;
        cyc(PF, 6'h00, 6'h00, 1'b1);
        cyc(PF, 6'h00, 6'h00, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        repeat (fw) cyc(PF, op, fn, 1'b0);
        cyc(PF, op, fn, 1'b1);
        cyc(PD, op, fn, 1'($urandom));
        if (op == 6'h00) begin
            cyc(PXR, op, fn, 1'($urandom)); cyc(PWB, op, fn, 1'($urandom));
        end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D}) begin
            cyc(PXI, op, fn, 1'($urandom)); cyc(PWB, op, fn, 1'($urandom));
        end else if (op == 6'h23) begin
            cyc(PMA, op, fn, 1'($urandom));
            repeat (mw) cyc(PMR, op, fn, 1'b0);
            cyc(PMR, op, fn, 1'b1);
            cyc(PMWB, op, fn, 1'($urandom));
        end else if (op == 6'h2B) begin
            cyc(PMA, op, fn, 1'($urandom));
            repeat (mw) cyc(PMW, op, fn, 1'b0);
            cyc(PMW, op, fn, 1'b1);
        end else if (op == 6'h04 || op == 6'h05) begin
            cyc(PBR, op, fn, 1'($urandom));
        end else begin
            cyc(PJ, op, fn, 1'($urandom));
        end
        m_ret = m_ret + 4'd1;
    endtask

    task automatic do_illegal(input logic [5:0] op, input logic [5:0] fn);
        cyc(PF, op, fn, 1'b1);
        cyc(PD, op, fn, 1'($urandom));
        m_ill = 1;
        repeat (3) cyc(PH, op, fn, 1'($urandom));
        do_reset();
    endtask

    // monitor: compare every cycle the stimulus has an expectation queued for
    always @(negedge clk) begin
        if (q.size() != 0) begin
            ctl_t a, e;
            int   ph;
            e  = q.pop_front();
            ph = pq.pop_front();
            a  = {PCWrite, PCWriteCond, Branch, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUCntl, PCSource, illegal, fault, retired};
            ck($sformatf("phase_%s", pname(ph)), 32'(a), 32'(e));
        end
    end

    initial begin
        m_ret = '0; m_ill = 0; m_flt = 0;
        @(posedge clk);
        #1;
        do_reset();
        do_instr(6'h00, 6'h20, 0, 0);
        do_instr(6'h23, 6'h00, 0, 3);
        do_instr(6'h04, 6'h00, 0, 0);
        do_instr(6'h05, 6'h00, 0, 0);
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(11)];
            do_instr(op, fns[$urandom_range(9)],
                     ($urandom_range(3) == 0) ? $urandom_range(T - 1) : 0,
                     ($urandom_range(2) == 0) ? $urandom_range(T - 1) : 0);
        end
        do_illegal(6'h3F, 6'h00);
        do_illegal(6'h00, 6'h3F);
        cyc(PF, 6'h2B, 6'h00, 1'b1);
        cyc(PD, 6'h2B, 6'h00, 1'b1);
        cyc(PMA, 6'h2B, 6'h00, 1'b1);
        repeat (T) cyc(PMW, 6'h2B, 6'h00, 1'b0);
        m_flt = 1;
        repeat (3) cyc(PH, 6'h2B, 6'h00, 1'($urandom));
        do_reset();
        ck("fault_cleared", 32'(fault), 32'd0);
        repeat (16) do_instr(6'h02, 6'h00, 0, 0);
        ck("retired_wrap", 32'(retired), 32'd0);
        cyc(PF, 6'h2B, 6'h00, 1'b1);
        cyc(PD, 6'h2B, 6'h00, 1'b1);
        cyc(PMA, 6'h2B, 6'h00, 1'b1);
        mem_ready = 1'b0;
        #1;
        ck("memwrite_before_reset", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        ck("memwrite_async_drop", 32'(MemWrite), 32'd0);
        ck("regwrite_in_reset", 32'(RegWrite), 32'd0);
        ck("fetch_in_reset", 32'(MemRead), 32'd1);
        do_reset();
        ck("retired_after_reset", 32'(retired), 32'd0);
        repeat (2) @(negedge clk);
        ck("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
